// File: rtl/voice_scheduler.sv
// Shares one voice datapath across all active voices per sample tick; sample_valid lands tick+3+A+L clks later.
// Requests hold until req_ready, capped at MAX_OUTSTANDING in flight; ticks arriving while busy are counted, not queued.
module voice_scheduler #(
  parameter int N_VOICES        = 8,
  parameter int SAMPLE_W        = 24,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        sample_tick,
  input  logic [N_VOICES-1:0]         voice_active,
  input  logic [31:0]                 master_volume,
  output logic                        req_valid,
  output logic [$clog2(N_VOICES)-1:0] req_idx,
  input  logic                        req_ready,
  input  logic                        rsp_valid,
  input  logic [SAMPLE_W-1:0]         rsp_data,
  output logic [SAMPLE_W-1:0]         sample_out,
  output logic                        sample_valid,
  output logic                        busy,
  output logic [7:0]                  overrun_cnt
);

  localparam int IDX_W  = $clog2(N_VOICES);
  localparam int ACC_W  = SAMPLE_W + IDX_W + 1;
  localparam int PROD_W = ACC_W + 17;
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, SCALE, OUTPUT} state_t;
  state_t state_q, state_d;

  logic [N_VOICES-1:0]      mask_q, issued_q, pending, idx_bit;
  logic [15:0]              vol_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [OUT_W-1:0]         outst_q;
  logic                     hs, rsp_take, frame_start;
  logic signed [PROD_W-1:0] prod, prod_sh;
  logic [PROD_W-SAMPLE_W:0] prod_top;
  logic [SAMPLE_W-1:0]      sat;
  logic                     unused_vol_hi;

  assign unused_vol_hi = ^master_volume[31:16];
  assign pending       = mask_q & ~issued_q;
  assign idx_bit       = N_VOICES'(1) << req_idx;
  assign frame_start   = (state_q == IDLE) && sample_tick;
  assign busy          = (state_q != IDLE);
  assign req_valid     = (state_q == ISSUE) && (pending != '0) &&
                         (outst_q < OUT_W'(MAX_OUTSTANDING));
  assign hs            = req_valid && req_ready;
  // Responses with nothing in flight are stray and must not touch the mix.
  assign rsp_take      = rsp_valid && (outst_q != '0);

  always_comb begin
    req_idx = '0;
    for (int i = N_VOICES - 1; i >= 0; i--) begin
      if (pending[i]) req_idx = IDX_W'(i);
    end
  end

  assign prod     = PROD_W'(acc_q) * PROD_W'($signed({1'b0, vol_q}));
  assign prod_sh  = prod >>> 16;
  assign prod_top = prod_sh[PROD_W-1:SAMPLE_W-1];

  always_comb begin
    sat = prod_sh[SAMPLE_W-1:0];
    if (prod_top != '0 && prod_top != '1) begin
      sat = prod_sh[PROD_W-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (sample_tick) state_d = ISSUE;
      ISSUE: begin
        if (pending == '0) state_d = SCALE;
        else if (hs && ((pending & ~idx_bit) == '0)) state_d = DRAIN;
      end
      DRAIN:  if (outst_q == '0) state_d = SCALE;
      SCALE:  state_d = OUTPUT;
      OUTPUT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mask_q       <= '0;
      issued_q     <= '0;
      vol_q        <= '0;
      acc_q        <= '0;
      outst_q      <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun_cnt  <= '0;
    end else begin
      sample_valid <= (state_q == SCALE);
      if (state_q == SCALE) sample_out <= sat;
      if (sample_tick && busy && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
      if (frame_start) begin
        mask_q   <= voice_active;
        vol_q    <= master_volume[15:0];
        issued_q <= '0;
        acc_q    <= '0;
        outst_q  <= '0;
      end else begin
        if (hs) issued_q <= issued_q | idx_bit;
        if (rsp_take) acc_q <= acc_q + ACC_W'($signed(rsp_data));
        case ({hs, rsp_take})
          2'b10:   outst_q <= outst_q + OUT_W'(1);
          2'b01:   outst_q <= outst_q - OUT_W'(1);
          default: outst_q <= outst_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed + randomized bench for voice_scheduler with an emulated in-order datapath
// and an arithmetic reference model of the mix.
module tb_voice_scheduler;

  logic        clk, rstn, sample_tick;
  logic [7:0]  voice_active;
  logic [31:0] master_volume;
  logic        req_valid, req_ready, rsp_valid;
  logic [2:0]  req_idx;
  logic [23:0] rsp_data, sample_out;
  logic        sample_valid, busy;
  logic [7:0]  overrun_cnt;

  voice_scheduler dut (
    .clk(clk), .rstn(rstn), .sample_tick(sample_tick), .voice_active(voice_active),
    .master_volume(master_volume), .req_valid(req_valid), .req_idx(req_idx),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .sample_out(sample_out), .sample_valid(sample_valid), .busy(busy),
    .overrun_cnt(overrun_cnt)
  );

  typedef struct { logic [2:0] idx; int due; } ent_t;

  int total = 0, bad = 0;
  int cyc = 0, sv_count = 0;
  int dp_lat = 2, ready_mode = 0, t_cyc = 0, junk_en = 0;
  int stall_err = 0, stall_seen = 0, max_out = 0;
  logic signed [23:0] vval [8];
  logic [2:0] issue_log [$];
  ent_t q [$];
  logic       prev_stall;
  logic [2:0] prev_idx;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (sample_valid === 1'b1) sv_count <= sv_count + 1;

  // Emulated shared datapath: in-order responses L clks after each handshake.
  initial begin
    rsp_valid = 1'b0; rsp_data = '0; req_ready = 1'b1; prev_stall = 1'b0; prev_idx = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        q.delete(); prev_stall = 1'b0;
      end else begin
        if (prev_stall && !(req_valid === 1'b1 && req_idx === prev_idx)) stall_err++;
        prev_stall = req_valid && !req_ready;
        prev_idx   = req_idx;
        if (req_valid && !req_ready) stall_seen++;
        if (rsp_valid && q.size() > 0) void'(q.pop_front());
        if (req_valid && req_ready) begin
          q.push_back('{idx: req_idx, due: cyc + dp_lat});
          issue_log.push_back(req_idx);
        end
        if (q.size() > max_out) max_out = q.size();
      end
      @(posedge clk); #1;
      if (q.size() > 0 && q[0].due <= cyc) begin
        rsp_valid = 1'b1; rsp_data = vval[q[0].idx];
      end else if (q.size() == 0 && junk_en != 0) begin
        rsp_valid = 1'($urandom_range(0, 1)); rsp_data = 24'($urandom);
      end else begin
        rsp_valid = 1'b0; rsp_data = 24'($urandom);
      end
      case (ready_mode)
        1:       req_ready = 1'($urandom_range(0, 1));
        2:       req_ready = !(cyc >= t_cyc + 3 && cyc <= t_cyc + 12);
        default: req_ready = 1'b1;
      endcase
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_sv(output bit ok, output int c);
    ok = 1'b0; c = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (sample_valid === 1'b1) begin ok = 1'b1; c = cyc; break; end
    end
  endtask

  // Reference: sum of active voices, times unsigned Q0.16 gain, floored, clamped.
  function automatic logic [23:0] model(input logic [7:0] mask, input logic [15:0] vol);
    longint s;
    s = 0;
    for (int i = 0; i < 8; i++) if (mask[i]) s += longint'(vval[i]);
    s = (s * longint'({48'd0, vol})) >>> 16;
    if (s > 64'sd8388607)  s = 64'sd8388607;
    if (s < -64'sd8388608) s = -64'sd8388608;
    return s[23:0];
  endfunction

  task automatic do_frame(input logic [7:0] mask, input logic [15:0] vol, input int lat,
                          input int rmode, input int extra, input string tag);
    logic [23:0] exp_s;
    logic [7:0]  ovr0;
    int a, base_log, base_sv, k, c;
    bit ok;
    dp_lat = lat; ready_mode = rmode;
    exp_s = model(mask, vol);
    a = $countones(mask);
    base_log = issue_log.size(); base_sv = sv_count; ovr0 = overrun_cnt;
    voice_active = mask; master_volume = {16'($urandom), vol};
    sample_tick = 1'b1; t_cyc = cyc; step(1); sample_tick = 1'b0;
    voice_active = 8'($urandom); master_volume = $urandom;
    for (int e = 0; e < extra; e++) begin
      step(1); sample_tick = 1'b1; step(1); sample_tick = 1'b0;
    end
    wait_sv(ok, c);
    check({tag, "_done"}, 64'(ok), 64'd1);
    check({tag, "_out"}, 64'(sample_out), 64'(exp_s));
    if (rmode == 0 && extra == 0) check({tag, "_lat"}, 64'(c - t_cyc), 64'(mask == 0 ? 3 : 3 + a + lat));
    check({tag, "_nreq"}, 64'(issue_log.size() - base_log), 64'(a));
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        if (base_log + k < issue_log.size()) check({tag, "_idx"}, 64'(issue_log[base_log + k]), 64'(i));
        k++;
      end
    end
    step(2);
    check({tag, "_nsv"}, 64'(sv_count - base_sv), 64'd1);
    check({tag, "_ovr"}, 64'(overrun_cnt), 64'(ovr0 + 8'(extra)));
  endtask

  initial begin
    int t0, c, base_sv;
    bit ok;
    logic [7:0] ovr0;
    rstn = 1'b0; sample_tick = 1'b0; voice_active = '0; master_volume = '0;
    for (int i = 0; i < 8; i++) vval[i] = '0;
    step(3);
    check("rst_req_valid", 64'(req_valid), 64'd0);
    check("rst_req_idx", 64'(req_idx), 64'd0);
    check("rst_sample_out", 64'(sample_out), 64'd0);
    check("rst_sample_valid", 64'(sample_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overrun", 64'(overrun_cnt), 64'd0);
    rstn = 1'b1; step(2);

    for (int i = 0; i < 8; i++) vval[i] = 24'sd1000;
    do_frame(8'hFF, 16'h8000, 2, 0, 0, "all8");

    for (int i = 0; i < 8; i++) vval[i] = 24'($urandom);
    vval[2] = -24'sd100; vval[5] = -24'sd200; vval[7] = 24'sd300;
    do_frame(8'b1010_0100, 16'hFFFF, 2, 0, 0, "sparse_zero");
    vval[2] = 24'sd100; vval[5] = 24'sd100; vval[7] = 24'sd100;
    do_frame(8'b1010_0100, 16'hFFFF, 3, 0, 0, "sparse_299");

    for (int i = 0; i < 8; i++) vval[i] = 24'($urandom);
    junk_en = 1;
    do_frame(8'hFF, 16'($urandom), 6, 2, 0, "stall");
    check("stall_stable", 64'(stall_err), 64'd0);
    check("stall_seen", 64'(stall_seen > 0), 64'd1);
    check("max_outstanding", 64'(max_out), 64'd4);

    for (int i = 0; i < 8; i++) vval[i] = 24'h7FFFFF;
    do_frame(8'hFF, 16'hFFFF, 2, 0, 0, "sat_pos");
    for (int i = 0; i < 8; i++) vval[i] = 24'h800000;
    do_frame(8'hFF, 16'hFFFF, 2, 0, 0, "sat_neg");

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) vval[i] = 24'($urandom);
      do_frame(8'($urandom), 16'($urandom), int'($urandom_range(1, 6)), 1, 0, "rand");
    end
    check("rand_stall_stable", 64'(stall_err), 64'd0);

    for (int i = 0; i < 8; i++) vval[i] = 24'sd5000;
    do_frame(8'hFF, 16'h4000, 2, 0, 0, "pre_zero");
    do_frame(8'h00, 16'hFFFF, 2, 0, 0, "mask_zero");

    for (int i = 0; i < 8; i++) vval[i] = 24'($urandom);
    do_frame(8'hFF, 16'($urandom), 5, 0, 3, "overrun");
    check("overrun_cnt3", 64'(overrun_cnt), 64'd3);

    // Tick in the sample_valid clk is an overrun; the one after starts a frame.
    ovr0 = overrun_cnt; junk_en = 0; dp_lat = 2; ready_mode = 0;
    voice_active = 8'h03; master_volume = 32'h0000_C000;
    sample_tick = 1'b1; t0 = cyc; step(1); sample_tick = 1'b0;
    step(6);
    check("edge_sv_now", 64'(sample_valid), 64'd1);
    sample_tick = 1'b1; step(1);
    check("edge_idle", 64'(busy), 64'd0);
    step(1); sample_tick = 1'b0;
    check("edge_new_busy", 64'(busy), 64'd1);
    check("edge_ovr", 64'(overrun_cnt), 64'(ovr0 + 8'd1));
    wait_sv(ok, c);
    check("edge_done", 64'(ok), 64'd1);
    check("edge_lat", 64'(c - t0), 64'd15);
    check("edge_out", 64'(sample_out), 64'(model(8'h03, 16'hC000)));

    // Reset in the middle of ISSUE abandons the frame.
    step(2);
    for (int i = 0; i < 8; i++) vval[i] = 24'($urandom);
    base_sv = sv_count; dp_lat = 8;
    voice_active = 8'hFF; master_volume = 32'h0000_7000;
    sample_tick = 1'b1; step(1); sample_tick = 1'b0;
    step(3);
    check("mid_busy", 64'(busy), 64'd1);
    rstn = 1'b0; #1;
    check("mid_rst_req_valid", 64'(req_valid), 64'd0);
    check("mid_rst_req_idx", 64'(req_idx), 64'd0);
    check("mid_rst_sample_out", 64'(sample_out), 64'd0);
    check("mid_rst_sample_valid", 64'(sample_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_overrun", 64'(overrun_cnt), 64'd0);
    step(2); rstn = 1'b1; step(2);
    check("mid_rst_no_sample", 64'(sv_count - base_sv), 64'd0);
    for (int i = 0; i < 8; i++) vval[i] = 24'($urandom);
    do_frame(8'($urandom) | 8'h01, 16'($urandom), 2, 0, 0, "post_rst");

    check("final_stall_stable", 64'(stall_err), 64'd0);
    check("final_max_outstanding", 64'(max_out), 64'd4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
